// File: rtl/seg7_bcd_display.sv
// Multi-digit 7-segment driver: sequential binary-to-BCD (shift-add-3), active-low encoding,
// leading-zero blanking, decimal points and overflow dashes. Optional hex mode: SEG7_HEX_MODE_EN.
module seg7_bcd_display #(
   parameter int DIGITS = 6,
   parameter int WIDTH  = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WIDTH-1:0]      value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  lzb,
`ifdef SEG7_HEX_MODE_EN
   input  logic                  hexmode,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [8*DIGITS-1:0]   hex
);

   localparam int          BW      = 4 * DIGITS;
   localparam int          CW      = $clog2(WIDTH + 1);
   localparam logic [31:0] MAX_DEC = 32'(10 ** DIGITS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [WIDTH-1:0]    sr_q, sr_d;
   logic [BW-1:0]       bcd_q, bcd_d, adj;
   logic [CW-1:0]       cnt_q;
   logic [DIGITS-1:0]   dp_q;
   logic                lzb_q;
   logic                ovf_pend_q;
   logic                busy_q, done_q, ovf_q;
   logic [8*DIGITS-1:0] hex_q, hex_d;
   logic [BW-1:0]       nibbles;
   logic                lead;
   logic [7:0]          seg;

`ifdef SEG7_HEX_MODE_EN
   logic                hexmode_q;
   logic [BW+WIDTH-1:0] hex_wide;
   // Zero-extend so nibbles above WIDTH read as 0; truncation drops nothing displayable.
   assign hex_wide = {{BW{1'b0}}, sr_q};
`endif

   function automatic logic [7:0] seg_encode(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;
         4'h1: return 8'hF9;
         4'h2: return 8'hA4;
         4'h3: return 8'hB0;
         4'h4: return 8'h99;
         4'h5: return 8'h92;
         4'h6: return 8'h82;
         4'h7: return 8'hF8;
         4'h8: return 8'h80;
         4'h9: return 8'h90;
         4'hA: return 8'h88;
         4'hB: return 8'h83;
         4'hC: return 8'hC6;
         4'hD: return 8'hA1;
         4'hE: return 8'h86;
         default: return 8'h8E;
      endcase
   endfunction

   // One shift-add-3 step: correct nibbles >= 5, then shift {bcd, binary} left.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_d = {adj[BW-2:0], sr_q[WIDTH-1]};
      sr_d  = sr_q << 1;
   end

   always_comb begin
      nibbles = bcd_q;
`ifdef SEG7_HEX_MODE_EN
      if (hexmode_q) nibbles = hex_wide[BW-1:0];
`endif
      hex_d = '1;
      lead  = 1'b1;
      seg   = 8'hFF;
      // Scan from the most significant digit so "lead" is true only above the first nonzero digit.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seg = seg_encode(nibbles[4*i +: 4]);
         if (nibbles[4*i +: 4] != 4'd0) lead = 1'b0;
         if (lzb_q && lead && i != 0) seg = 8'hFF;
         if (ovf_pend_q) seg = 8'hBF;
         if (dp_q[i]) seg[7] = 1'b0;
         hex_d[8*i +: 8] = seg;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (reset) begin
         state_q    <= S_IDLE;
         sr_q       <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         dp_q       <= '0;
         lzb_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         hex_q      <= '1;
`ifdef SEG7_HEX_MODE_EN
         hexmode_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  sr_q       <= value;
                  bcd_q      <= '0;
                  cnt_q      <= CW'(WIDTH);
                  dp_q       <= dp;
                  lzb_q      <= lzb;
                  ovf_pend_q <= (32'(value) >= MAX_DEC);
                  busy_q     <= 1'b1;
                  state_q    <= S_CONVERT;
`ifdef SEG7_HEX_MODE_EN
                  hexmode_q  <= hexmode;
                  if (hexmode) begin
                     ovf_pend_q <= 1'b0;
                     state_q    <= S_UPDATE;
                  end
`endif
               end
            end
            S_CONVERT: begin
               bcd_q <= bcd_d;
               sr_q  <= sr_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= S_UPDATE;
            end
            S_UPDATE: begin
               hex_q   <= hex_d;
               ovf_q   <= ovf_pend_q;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               // Busy stays high through the done cycle so a load there is ignored.
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;
   assign hex  = hex_q;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Randomised self-checking bench for seg7_bcd_display against an arithmetic digit model.
module tb_seg7_bcd_display;

   localparam int D = 6;
   localparam int W = 20;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           load = 1'b0;
   logic [W-1:0]   value = '0;
   logic [D-1:0]   dp = '0;
   logic           lzb = 1'b0;
`ifdef SEG7_HEX_MODE_EN
   logic           hexmode = 1'b0;
`endif
   logic           busy, done, ovf;
   logic [8*D-1:0] hex;

   int             checks = 0;
   int             failures = 0;
   logic [8*D-1:0] exp_hex = '1;
   logic           exp_ovf = 1'b0;

   always #5 clk = ~clk;

   seg7_bcd_display #(.DIGITS(D), .WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .value  (value),
      .dp     (dp),
      .lzb    (lzb),
`ifdef SEG7_HEX_MODE_EN
      .hexmode(hexmode),
`endif
      .busy   (busy),
      .done   (done),
      .ovf    (ovf),
      .hex    (hex)
   );

   function automatic logic [7:0] seg_of(input int n);
      logic [7:0] tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return tab[n];
   endfunction

   function automatic logic model_ovf(input longint unsigned v, input logic hm);
      longint unsigned lim = 1;
      for (int i = 0; i < D; i++) lim = lim * 10;
      return !hm && (v >= lim);
   endfunction

   function automatic logic [8*D-1:0] model_hex(input longint unsigned v, input logic [D-1:0] dpv,
                                                input logic lz, input logic hm);
      int              dig [D];
      int              msd = -1;
      longint unsigned t = v;
      logic [7:0]      s;
      logic [8*D-1:0]  r = '1;
      logic            ov = model_ovf(v, hm);
      for (int i = 0; i < D; i++) begin
         dig[i] = hm ? int'((v >> (4 * i)) & 64'd15) : int'(t % 10);
         t = t / 10;
         if (dig[i] != 0) msd = i;
      end
      for (int i = 0; i < D; i++) begin
         if (ov) s = 8'hBF;
         else if (lz && i > 0 && i > msd) s = 8'hFF;
         else s = seg_of(dig[i]);
         if (dpv[i]) s[7] = 1'b0;
         r[8*i +: 8] = s;
      end
      return r;
   endfunction

   // Runs one conversion, checking busy/done/hex/ovf after every edge; inject_at > 0 raises
   // an extra load after that edge, which must be ignored.
   task automatic run_conv(input logic [W-1:0] v, input logic [D-1:0] dpv, input logic lz,
                           input logic hm, input int inject_at, input string tag);
      int             lat = hm ? 0 : W;
      logic [8*D-1:0] prev = exp_hex;
      logic           prev_ovf = exp_ovf;
      logic [8*D-1:0] want = model_hex(longint'(v), dpv, lz, hm);
      logic           want_ovf = model_ovf(longint'(v), hm);
      logic           eb, ed, eo;
      logic [8*D-1:0] eh;
      @(negedge clk);
      value = v; dp = dpv; lzb = lz; load = 1'b1;
`ifdef SEG7_HEX_MODE_EN
      hexmode = hm;
`endif
      @(negedge clk);
      load = 1'b0; value = W'($urandom); dp = D'($urandom); lzb = 1'(($urandom));
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL %s busy_after_accept got=%b exp=1", tag, busy);
      end
      for (int k = 1; k <= lat + 2; k++) begin
         @(posedge clk); #1;
         eb = (k <= lat + 1);
         ed = (k == lat + 1);
         eh = (k > lat) ? want : prev;
         eo = (k > lat) ? want_ovf : prev_ovf;
         checks++;
         if (busy !== eb) begin
            failures++;
            $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, busy, eb);
         end
         checks++;
         if (done !== ed) begin
            failures++;
            $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done, ed);
         end
         checks++;
         if (hex !== eh) begin
            failures++;
            $display("FAIL %s hex k=%0d got=%h exp=%h", tag, k, hex, eh);
         end
         checks++;
         if (ovf !== eo) begin
            failures++;
            $display("FAIL %s ovf k=%0d got=%b exp=%b", tag, k, ovf, eo);
         end
         load = (k == inject_at);
         if (k == inject_at) value = W'($urandom);
      end
      load = 1'b0;
      exp_hex = want;
      exp_ovf = want_ovf;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s idle_after got busy=%b done=%b exp busy=0 done=0", tag, busy, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (hex !== '1 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got hex=%h busy=%b done=%b ovf=%b exp hex=%h 0 0 0",
                  hex, busy, done, ovf, {8*D{1'b1}});
      end
      reset = 1'b0;
      exp_hex = '1;
      exp_ovf = 1'b0;
   endtask

   task automatic check_hex(input logic [8*D-1:0] want, input logic want_ovf, input string tag);
      checks++;
      if (hex !== want || ovf !== want_ovf) begin
         failures++;
         $display("FAIL %s got hex=%h ovf=%b exp hex=%h ovf=%b", tag, hex, ovf, want, want_ovf);
      end
   endtask

   task automatic test_decimal();
      run_conv(W'(123456), '0, 1'b0, 1'b0, 0, "dec123456");
      check_hex(48'hF9A4B0999282, 1'b0, "dec123456_const");
      run_conv(W'(42), 6'b000010, 1'b1, 1'b0, 0, "lzb_dp42");
      check_hex(48'hFFFFFFFF19A4, 1'b0, "lzb_dp42_const");
   endtask

   task automatic test_zero();
      run_conv(W'(0), '0, 1'b1, 1'b0, 0, "zero_lzb");
      check_hex(48'hFFFFFFFFFFC0, 1'b0, "zero_lzb_const");
      run_conv(W'(0), '0, 1'b0, 1'b0, 0, "zero_nolzb");
      check_hex(48'hC0C0C0C0C0C0, 1'b0, "zero_nolzb_const");
   endtask

   task automatic test_overflow();
      run_conv(W'(1000000), '0, 1'b0, 1'b0, 0, "ovf1e6");
      check_hex(48'hBFBFBFBFBFBF, 1'b1, "ovf1e6_const");
      run_conv(W'(7), '0, 1'b0, 1'b0, 0, "after_ovf7");
      check_hex(48'hC0C0C0C0C0F8, 1'b0, "after_ovf7_const");
      run_conv(W'(999999), '0, 1'b1, 1'b0, 0, "max999999");
      check_hex(48'h909090909090, 1'b0, "max999999_const");
   endtask

   task automatic test_load_while_busy();
      run_conv(W'(555555), '0, 1'b0, 1'b0, 5, "busy_load");
      check_hex(48'h929292929292, 1'b0, "busy_load_const");
      run_conv(W'(314159), 6'b100001, 1'b1, 1'b0, W + 1, "load_in_done");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      value = W'(271828); dp = '0; lzb = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (hex !== '1 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid got hex=%h busy=%b done=%b ovf=%b exp all-ones 0 0 0",
                  hex, busy, done, ovf);
      end
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || hex !== '1) begin
            failures++;
            $display("FAIL reset_mid_quiet k=%0d got done=%b busy=%b hex=%h exp 0 0 all-ones",
                     k, done, busy, hex);
         end
      end
      exp_hex = '1;
      exp_ovf = 1'b0;
   endtask

   task automatic test_random();
      logic hm;
      for (int n = 0; n < 25; n++) begin
         hm = 1'b0;
`ifdef SEG7_HEX_MODE_EN
         hm = 1'(($urandom));
`endif
         run_conv(W'($urandom_range(0, (1 << W) - 1)), D'($urandom), 1'(($urandom)), hm,
                  int'($urandom_range(0, W + 4)), $sformatf("rand%0d", n));
      end
   endtask

`ifdef SEG7_HEX_MODE_EN
   task automatic test_hexmode();
      run_conv(20'hABCDE, '0, 1'b1, 1'b1, 0, "hexmode");
      check_hex(48'hFF8883C6A186, 1'b0, "hexmode_const");
   endtask
`endif

   initial begin
      test_reset();
      test_decimal();
      test_zero();
      test_overflow();
      test_load_while_busy();
      test_reset_mid();
`ifdef SEG7_HEX_MODE_EN
      test_hexmode();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
